// File: rtl/button_conditioner.sv
// button_conditioner: conditions the five raw board push-buttons for the
// game plane.
//   - Each raw input passes through a 2-flop synchroniser into pixel_clk.
//   - It is then debounced into a stable level.
//   - A one-cycle press pulse is made on each debounced rise, and a
//     one-cycle release pulse on each debounced fall.
//
// Ports (bit order {C,U,D,R,L} = [4:0]):
//   pixel_clk     in   the only clock
//   rst           in   synchronous reset, active high
//   btn_raw[4:0]  in   raw asynchronous buttons, 1 = pressed
//   btn_level     out  debounced stable level (registered)
//   btn_press     out  one-cycle pulse per debounced 0->1 (plus auto-repeat)
//   btn_release   out  one-cycle pulse per debounced 1->0
//   any_activity  out  registered OR of all press/release pulses
//
// Build option: define BUTTON_CONDITIONER_AUTOREPEAT_EN to add auto-repeat
// press pulses on bits [3:0]. The C button (bit 4) never repeats.

// Per-button debounce FSM. The optional repeat counter is present only
// when REPEAT_EN is set.
module button_debounce #(
   parameter int DEBOUNCE_CYCLES = 360000,
   parameter int CNT_W           = 19,
   parameter int REPEAT_DELAY    = 18000000,
   parameter int REPEAT_PERIOD   = 3600000,
   parameter int REP_W           = 25,
   parameter bit REPEAT_EN       = 1'b0
) (
   input  logic pixel_clk,
   input  logic rst,
   input  logic sync_in,
   output logic level,
   output logic press,
   output logic rel
);

   typedef enum logic [1:0] {STABLE_LO, CHK_HI, STABLE_HI, CHK_LO} state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             level_q, level_d;
   logic             press_q, press_d;
   logic             rel_q, rel_d;
   logic             rep_fire;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         STABLE_LO: begin
            if (sync_in) begin
               state_d = CHK_HI;
               cnt_d   = CNT_ONE;
            end else begin
               cnt_d = '0;
            end
         end
         CHK_HI: begin
            if (!sync_in) begin
               state_d = STABLE_LO;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = STABLE_HI;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         STABLE_HI: begin
            if (!sync_in) begin
               state_d = CHK_LO;
               cnt_d   = CNT_ONE;
            end else begin
               cnt_d = '0;
            end
         end
         CHK_LO: begin
            if (sync_in) begin
               state_d = STABLE_HI;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = STABLE_LO;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = STABLE_LO;
            cnt_d   = '0;
         end
      endcase
   end

   // Level is a registered decode of the current state, so level, press and
   // release all change on the same edge, one cycle after the state flips.
   always_comb begin
      level_d = (state_q == STABLE_HI) || (state_q == CHK_LO);
      press_d = (level_d & ~level_q) | rep_fire;
      rel_d   = ~level_d & level_q;
   end

   generate
      if (REPEAT_EN) begin : g_rep
         localparam logic [REP_W-1:0] REP_LAST   = REP_W'(REPEAT_DELAY - 1);
         localparam logic [REP_W-1:0] REP_RELOAD = REP_W'(REPEAT_DELAY - REPEAT_PERIOD);

         logic [REP_W-1:0] rep_q, rep_d;

         // Counting is gated by the visible level as well as the state. This
         // makes the first repeat land exactly REPEAT_DELAY cycles after the
         // rising-edge press pulse. Reloading to DELAY-PERIOD spaces later
         // repeats REPEAT_PERIOD apart without ever exceeding DELAY-1.
         always_comb begin
            rep_d    = '0;
            rep_fire = 1'b0;
            if ((state_q == STABLE_HI) && level_q) begin
               if (rep_q == REP_LAST) begin
                  rep_fire = 1'b1;
                  rep_d    = REP_RELOAD;
               end else begin
                  rep_d = rep_q + REP_W'(1);
               end
            end
         end

         always_ff @(posedge pixel_clk) begin
            if (rst) rep_q <= '0;
            else     rep_q <= rep_d;
         end
      end else begin : g_norep
         assign rep_fire = 1'b0;
      end
   endgenerate

   always_ff @(posedge pixel_clk) begin
      if (rst) begin
         state_q <= STABLE_LO;
         cnt_q   <= '0;
         level_q <= 1'b0;
         press_q <= 1'b0;
         rel_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         press_q <= press_d;
         rel_q   <= rel_d;
      end
   end

   assign level = level_q;
   assign press = press_q;
   assign rel   = rel_q;

endmodule

module button_conditioner #(
   parameter int DEBOUNCE_CYCLES = 360000,
   parameter int CNT_W           = 19,
   parameter int REPEAT_DELAY    = 18000000,
   parameter int REPEAT_PERIOD   = 3600000,
   parameter int REP_W           = 25
) (
   input  logic       pixel_clk,
   input  logic       rst,
   input  logic [4:0] btn_raw,
   output logic [4:0] btn_level,
   output logic [4:0] btn_press,
   output logic [4:0] btn_release,
   output logic       any_activity
);

   localparam int NUM_BTN = 5;
`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
   localparam bit AR_EN = 1'b1;
`else
   localparam bit AR_EN = 1'b0;
`endif

   logic [NUM_BTN-1:0] sync1_q, sync1_d;
   logic [NUM_BTN-1:0] sync2_q, sync2_d;
   logic               any_q, any_d;
   logic [NUM_BTN-1:0] lvl, prs, rls;

   always_comb begin
      sync1_d = btn_raw;
      sync2_d = sync1_q;
      any_d   = |(prs | rls);
   end

   always_ff @(posedge pixel_clk) begin
      if (rst) begin
         sync1_q <= '0;
         sync2_q <= '0;
         any_q   <= 1'b0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         any_q   <= any_d;
      end
   end

   generate
      for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
         // Bit 4 (C) drives regime changes, so it must stay one-per-press.
         button_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD),
            .REP_W           (REP_W),
            .REPEAT_EN       (AR_EN && (i != 4))
         ) u_db (
            .pixel_clk (pixel_clk),
            .rst       (rst),
            .sync_in   (sync2_q[i]),
            .level     (lvl[i]),
            .press     (prs[i]),
            .rel       (rls[i])
         );
      end
   endgenerate

   assign btn_level    = lvl;
   assign btn_press    = prs;
   assign btn_release  = rls;
   assign any_activity = any_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner with DEBOUNCE_CYCLES=4,
// REPEAT_DELAY=10 and REPEAT_PERIOD=3.
// A raw change driven at the negedge of cycle c is sampled at edge c+1.
// Its level and press/release pulse appear after edge c+1+6, and
// any_activity follows one cycle later. Expected pulse events are queued
// with their cycle when stimulus is driven. Every cycle, the monitor pops
// the events due and compares all four outputs.
module tb_button_conditioner;

   logic       pixel_clk = 1'b0;
   logic       rst = 1'b1;
   logic [4:0] btn_raw = '0;
   logic [4:0] btn_level, btn_press, btn_release;
   logic       any_activity;

   button_conditioner #(
      .DEBOUNCE_CYCLES (4),
      .CNT_W           (19),
      .REPEAT_DELAY    (10),
      .REPEAT_PERIOD   (3),
      .REP_W           (25)
   ) dut (
      .pixel_clk    (pixel_clk),
      .rst          (rst),
      .btn_raw      (btn_raw),
      .btn_level    (btn_level),
      .btn_press    (btn_press),
      .btn_release  (btn_release),
      .any_activity (any_activity)
   );

   always #5 pixel_clk = ~pixel_clk;

   int cyc = 0;
   always @(posedge pixel_clk) cyc <= cyc + 1;

   typedef enum int {E_PRESS, E_REL, E_ACT, E_RST} kind_t;
   typedef struct {
      int         cyc;
      kind_t      kind;
      logic [4:0] mask;
   } evt_t;

   evt_t       sb[$];
   int         n_chk = 0;
   int         n_err = 0;
   logic [4:0] exp_lvl = '0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
      end
   endtask

   task automatic push(input int c, input kind_t k, input logic [4:0] m);
      evt_t e;
      e.cyc  = c;
      e.kind = k;
      e.mask = m;
      sb.push_back(e);
   endtask

   task automatic exp_press(input int c, input logic [4:0] m);
      push(c, E_PRESS, m);
      push(c + 1, E_ACT, m);
   endtask

   task automatic exp_rel(input int c, input logic [4:0] m);
      push(c, E_REL, m);
      push(c + 1, E_ACT, m);
   endtask

   task automatic at_cyc(input int k);
      do @(negedge pixel_clk); while (cyc < k);
   endtask

   // Monitor: pop the events due this cycle and compare every output.
   logic [4:0] ep, er;
   logic       ea, erst;
   always @(negedge pixel_clk) begin
      ep   = '0;
      er   = '0;
      ea   = 1'b0;
      erst = 1'b0;
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].cyc == cyc) begin
            case (sb[i].kind)
               E_PRESS: ep   = ep | sb[i].mask;
               E_REL:   er   = er | sb[i].mask;
               E_ACT:   ea   = 1'b1;
               default: erst = 1'b1;
            endcase
            sb.delete(i);
         end
      end
      if (erst) exp_lvl = '0;
      exp_lvl = (exp_lvl | ep) & ~er;
      chk("press",   32'(btn_press),    32'(ep));
      chk("release", 32'(btn_release),  32'(er));
      chk("any",     32'(any_activity), 32'(ea));
      chk("level",   32'(btn_level),    32'(exp_lvl));
   end

   initial begin
      #100000;
      $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset, then release it.
      rst = 1'b1;
      at_cyc(2);
      rst = 1'b0;

      // Clean press of C (sampled at edge 10), then a clean release.
      at_cyc(9);
      btn_raw[4] = 1'b1;
      exp_press(16, 5'b10000);
      at_cyc(30);
      btn_raw[4] = 1'b0;
      exp_rel(37, 5'b10000);

      // Three-cycle glitch on L: one cycle too short, so no event is expected.
      at_cyc(45);
      btn_raw[0] = 1'b1;
      at_cyc(48);
      btn_raw[0] = 1'b0;

      // Press D, then release it with bounces. The last edge is sampled at
      // edge 77.
      at_cyc(60);
      btn_raw[2] = 1'b1;
      exp_press(67, 5'b00100);
      at_cyc(72); btn_raw[2] = 1'b0;
      at_cyc(73); btn_raw[2] = 1'b1;
      at_cyc(74); btn_raw[2] = 1'b0;
      at_cyc(75); btn_raw[2] = 1'b1;
      at_cyc(76); btn_raw[2] = 1'b0;
      exp_rel(83, 5'b00100);

      // All five buttons pressed at once.
      at_cyc(95);
      btn_raw = 5'h1f;
      exp_press(102, 5'h1f);
      // Drop the buttons briefly so every FSM enters CHK_LO. Raise them
      // again, then reset.
      at_cyc(105); btn_raw = 5'h00;
      at_cyc(107); btn_raw = 5'h1f;
      at_cyc(108); rst = 1'b1;
      push(109, E_RST, 5'h00);
      at_cyc(109); rst = 1'b0;
      // Raw is still high, so the buttons are pressed again from clean sync
      // flops.
      exp_press(116, 5'h1f);
`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
      exp_press(126, 5'h0f);
      exp_press(129, 5'h0f);
      exp_press(132, 5'h0f);
`endif
      at_cyc(130);
      btn_raw = 5'h00;
      exp_rel(137, 5'h1f);

      at_cyc(150);
      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
